instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage of the LEGv8 core: holds the program counter, issues word requests to instruction memory over a req/ack handshake, and presents each fetched 32-bit instruction with its PC and opcode field (bits 31:21) to the decode/control stage over a valid/ready handshake. Accepts PC redirects from the branch-resolution logic and discards any instruction fetched down the wrong path.

## Interface
- `PC_WIDTH`, 64, width of PC and memory address.
- `RESET_PC`, 64'h0, PC value loaded at reset.

- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request, level; held until `imem_ack`.
- `imem_addr` out PC_WIDTH: byte address of requested word; stable while `imem_req`=1.
- `imem_ack` in 1: memory returns `imem_rdata` this cycle; ignored when `imem_req`=0.
- `imem_rdata` in 32: instruction word, valid with `imem_ack`.
- `branch_redirect` in 1: single-cycle pulse; next fetch from `branch_target`.
- `branch_target` in PC_WIDTH: redirect address.
- `inst_valid` out 1: `instruction`/`inst_pc`/`opcode` valid.
- `inst_ready` in 1: decode consumes the instruction when `inst_valid`&&`inst_ready`.
- `instruction` out 32: held instruction word.
- `inst_pc` out PC_WIDTH: address of held instruction.
- `opcode` out 11: `instruction[31:21]`, combinational from the holding register.
- `fetch_fault` out 1: misaligned redirect trap (see Configuration).

## Operation
- Registers: `pc`, `req_addr`, `inst_reg`, `inst_pc_reg`, 2-bit `state` in {IDLE, FETCH, HOLD, DRAIN} plus FAULT when configured.
- IDLE: reset state; unconditionally to FETCH next cycle.
- FETCH: `imem_req`=1, `imem_addr`=`pc`, `req_addr`<=`pc`. On `imem_ack`: `inst_reg`<=`imem_rdata`, `inst_pc_reg`<=`pc`, `pc`<=`pc`+4 (wraps modulo 2^PC_WIDTH), go HOLD.
- HOLD: `inst_valid`=1, `imem_req`=0. On `inst_ready`: go FETCH.
- DRAIN: wrong-path request outstanding; `imem_req`=1, `imem_addr`=`req_addr`; on `imem_ack` drop data, go FETCH.
- Redirect (`branch_redirect`=1), always overriding the above: `pc`<=`branch_target`.
  - In FETCH without ack: go DRAIN (request is never withdrawn mid-handshake).
  - In FETCH with ack same cycle: data discarded, go FETCH.
  - In HOLD (with or without `inst_ready`): held instruction discarded, go FETCH; `inst_valid` low next cycle.
  - In DRAIN: update `pc`, stay DRAIN unless ack, then FETCH.
  - In IDLE: update `pc`, go FETCH.
- Outputs in reset: `imem_req`=0, `imem_addr`=RESET_PC, `inst_valid`=0, `instruction`=0, `inst_pc`=0, `opcode`=0, `fetch_fault`=0; `pc`=RESET_PC.

## Timing
- First request: cycle 1 after `rst_n` deassertion (cycle 0 in IDLE).
- Ack in request cycle N: `inst_valid`=1 from cycle N+1.
- Back-to-back with zero-wait memory and `inst_ready`=1: one instruction per 2 cycles.
- Redirect in cycle N with no outstanding request: request to `branch_target` in cycle N+1.
- `inst_valid` and held outputs stable while `inst_ready`=0.
- Reset assertion mid-handshake: all state cleared immediately; any in-flight ack is ignored.

## Configuration
- `IF_MISALIGN_TRAP_EN` defined: redirect with `branch_target[1:0]`≠0 enters FAULT: `fetch_fault`=1 from next cycle, sticky; `imem_req`=0, `inst_valid`=0 until reset; an outstanding request is abandoned (memory must tolerate it).
- Not defined: `branch_target[1:0]` forced to 0 on load, FAULT state absent, `fetch_fault` tied 0.

## Test plan
- Reset release, zero-wait memory returning 32'h8B020020 at 0x0, `inst_ready`=1 -> `imem_req` cycle 1 addr 0x0; `inst_valid` cycle 2, `opcode`=11'h458, `inst_pc`=0; next request addr 0x4 cycle 3.
- Ack delayed 3 cycles, `inst_ready`=0 for 4 cycles after valid -> `imem_addr` stable during wait; outputs held unchanged until ready.
- Redirect to 0x100 while request to 0x8 outstanding, ack 2 cycles later -> data for 0x8 never presented; next request addr 0x100.
- Redirect to 0x40 in HOLD with `inst_ready`=1 same cycle -> `inst_valid` low next cycle, request to 0x40 next cycle.
- PC=0xFFFF_FFFF_FFFF_FFFC fetched -> next request addr 0x0.
- With `IF_MISALIGN_TRAP_EN`, redirect to 0x102 -> `fetch_fault`=1 next cycle, no further requests until `rst_n` low; without macro, next request addr 0x100.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: imem req/ack, branch redirect and decode valid/ready bundle of the fetch stage.
interface instruction_fetch_if #(parameter int PC_WIDTH = 64);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [31:0]         imem_rdata;
    logic                branch_redirect;
    logic [PC_WIDTH-1:0] branch_target;
    logic                inst_valid;
    logic                inst_ready;
    logic [31:0]         instruction;
    logic [PC_WIDTH-1:0] inst_pc;
    logic [10:0]         opcode;
    logic                fetch_fault;

    modport master (
        output imem_req, imem_addr, inst_valid, instruction, inst_pc, opcode, fetch_fault,
        input  imem_ack, imem_rdata, branch_redirect, branch_target, inst_ready
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, instruction, inst_pc, opcode, fetch_fault,
        output imem_ack, imem_rdata, branch_redirect, branch_target, inst_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: LEGv8 fetch stage with PC, imem req/ack, decode valid/ready and branch redirect.
// IF_MISALIGN_TRAP_EN: misaligned redirect traps into a sticky FAULT state instead of masking.
module instruction_fetch #(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input logic                 clk,
    input logic                 rst_n,
    instruction_fetch_if.master bus
);
`ifdef IF_MISALIGN_TRAP_EN
    typedef enum logic [2:0] {IDLE, FETCH, HOLD, DRAIN, FAULT} state_e;
`else
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_e;
`endif

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d, req_addr_q, req_addr_d, inst_pc_q, inst_pc_d, tgt;
    logic [31:0]         inst_q, inst_d;
    logic                redir;

`ifdef IF_MISALIGN_TRAP_EN
    assign tgt = bus.branch_target;
`else
    assign tgt = bus.branch_target & ~PC_WIDTH'(3);
`endif
    assign redir = bus.branch_redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            inst_q     <= '0;
            inst_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: begin
                req_addr_d = pc_q;
                if (bus.imem_ack && !redir) begin
                    inst_d    = bus.imem_rdata;
                    inst_pc_d = pc_q;
                    pc_d      = pc_q + PC_WIDTH'(4);
                    state_d   = HOLD;
                end else if (redir) begin
                    // an unacked request stays on the bus until memory answers it
                    state_d = bus.imem_ack ? FETCH : DRAIN;
                end
            end
            HOLD:  state_d = (bus.inst_ready || redir) ? FETCH : HOLD;
            DRAIN: state_d = bus.imem_ack ? FETCH : DRAIN;
            default: ;
        endcase
        if (redir) pc_d = tgt;
`ifdef IF_MISALIGN_TRAP_EN
        if ((redir && |bus.branch_target[1:0]) || state_q == FAULT) state_d = FAULT;
`endif
    end

    assign bus.imem_req    = (state_q == FETCH) || (state_q == DRAIN);
    assign bus.imem_addr   = (state_q == DRAIN) ? req_addr_q : pc_q;
    assign bus.inst_valid  = state_q == HOLD;
    assign bus.instruction = inst_q;
    assign bus.inst_pc     = inst_pc_q;
    assign bus.opcode      = inst_q[31:21];
`ifdef IF_MISALIGN_TRAP_EN
    assign bus.fetch_fault = state_q == FAULT;
`else
    assign bus.fetch_fault = 1'b0;
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios plus randomized run against a program-order stream model.
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   lat = 0;
    int   wcnt = 0;

    instruction_fetch_if #(.PC_WIDTH(64)) bus();
    instruction_fetch #(.PC_WIDTH(64), .RESET_PC(64'h0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [63:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ 32'h8B020020;
    endfunction

    task automatic mem_drive();
        if (bus.imem_req) begin
            bus.imem_ack   = (wcnt >= lat);
            bus.imem_rdata = bus.imem_ack ? mem(bus.imem_addr) : $urandom;
            wcnt           = bus.imem_ack ? 0 : wcnt + 1;
        end else begin
            bus.imem_ack   = 1'b0;
            bus.imem_rdata = $urandom;
            wcnt           = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        mem_drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.branch_redirect = 1'b0;
        bus.branch_target = '0;
        bus.inst_ready = 1'b0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        wcnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_drive();
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", bus.imem_req); end
        checks++; if (bus.imem_addr !== 64'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", bus.imem_addr); end
        checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", bus.inst_valid); end
        checks++; if (bus.instruction !== 32'h0) begin failures++; $display("FAIL rst_inst got=%h exp=0", bus.instruction); end
        checks++; if (bus.inst_pc !== 64'h0) begin failures++; $display("FAIL rst_pc got=%h exp=0", bus.inst_pc); end
        checks++; if (bus.opcode !== 11'h0) begin failures++; $display("FAIL rst_opcode got=%h exp=0", bus.opcode); end
        checks++; if (bus.fetch_fault !== 1'b0) begin failures++; $display("FAIL rst_fault got=%0b exp=0", bus.fetch_fault); end
        do_reset();
        lat = 5;
        step();
        checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL rst_mid_req_pre got=%0b exp=1", bus.imem_req); end
        #2 rst_n = 1'b0;
        bus.imem_ack = 1'b1;
        #1;
        checks++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_async got=req%0b/valid%0b exp=0/0", bus.imem_req, bus.inst_valid); end
        @(posedge clk);
        #1;
        checks++; if (bus.inst_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_ack_ignored got=%0b exp=0", bus.inst_valid); end
        lat = 0;
    endtask

    task automatic test_basic();
        lat = 0;
        do_reset();
        bus.inst_ready = 1'b1;
        checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL basic_c0_req got=%0b exp=0", bus.imem_req); end
        step();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) begin failures++; $display("FAIL basic_c1_req got=%0b/%h exp=1/0", bus.imem_req, bus.imem_addr); end
        step();
        checks++; if (bus.inst_valid !== 1'b1 || bus.opcode !== 11'h458 || bus.inst_pc !== 64'h0 || bus.instruction !== 32'h8B020020)
            begin failures++; $display("FAIL basic_c2_out got=%0b/%h/%h/%h exp=1/458/0/8b020020", bus.inst_valid, bus.opcode, bus.inst_pc, bus.instruction); end
        step();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h4 || bus.inst_valid !== 1'b0) begin failures++; $display("FAIL basic_c3_req got=%0b/%h/%0b exp=1/4/0", bus.imem_req, bus.imem_addr, bus.inst_valid); end
    endtask

    task automatic test_wait_hold();
        lat = 3;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            step();
            checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0 || bus.inst_valid !== 1'b0)
                begin failures++; $display("FAIL wait_addr c%0d got=%0b/%h/%0b exp=1/0/0", i, bus.imem_req, bus.imem_addr, bus.inst_valid); end
        end
        for (int i = 5; i <= 8; i++) begin
            step();
            checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'h0 || bus.instruction !== mem(64'h0) || bus.imem_req !== 1'b0)
                begin failures++; $display("FAIL hold_stable c%0d got=%0b/%h/%h exp=1/0/%h", i, bus.inst_valid, bus.inst_pc, bus.instruction, mem(64'h0)); end
        end
        step();
        bus.inst_ready = 1'b1;
        step();
        bus.inst_ready = 1'b0;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h4 || bus.inst_valid !== 1'b0)
            begin failures++; $display("FAIL hold_release got=%0b/%h/%0b exp=1/4/0", bus.imem_req, bus.imem_addr, bus.inst_valid); end
        lat = 0;
    endtask

    task automatic test_redirect_drain();
        bit seen;
        lat = 0;
        do_reset();
        bus.inst_ready = 1'b1;
        repeat (4) step();
        lat = 2;
        step();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h8) begin failures++; $display("FAIL drain_pre got=%0b/%h exp=1/8", bus.imem_req, bus.imem_addr); end
        bus.branch_redirect = 1'b1;
        bus.branch_target = 64'h100;
        step();
        bus.branch_redirect = 1'b0;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h8 || bus.inst_valid !== 1'b0)
            begin failures++; $display("FAIL drain_hold got=%0b/%h/%0b exp=1/8/0", bus.imem_req, bus.imem_addr, bus.inst_valid); end
        step();
        step();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h100 || bus.inst_valid !== 1'b0)
            begin failures++; $display("FAIL drain_next got=%0b/%h/%0b exp=1/100/0", bus.imem_req, bus.imem_addr, bus.inst_valid); end
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = bus.inst_valid;
        end
        checks++; if (!seen || bus.inst_pc !== 64'h100 || bus.instruction !== mem(64'h100))
            begin failures++; $display("FAIL drain_first got=%0b/%h/%h exp=1/100/%h", seen, bus.inst_pc, bus.instruction, mem(64'h100)); end
    endtask

    task automatic test_redirect_hold();
        lat = 0;
        do_reset();
        bus.inst_ready = 1'b1;
        step();
        step();
        checks++; if (bus.inst_valid !== 1'b1) begin failures++; $display("FAIL rhold_pre got=%0b exp=1", bus.inst_valid); end
        bus.branch_redirect = 1'b1;
        bus.branch_target = 64'h40;
        step();
        bus.branch_redirect = 1'b0;
        checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h40)
            begin failures++; $display("FAIL rhold_next got=%0b/%0b/%h exp=0/1/40", bus.inst_valid, bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_wrap();
        lat = 0;
        do_reset();
        bus.inst_ready = 1'b1;
        bus.branch_redirect = 1'b1;
        bus.branch_target = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        bus.branch_redirect = 1'b0;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_req got=%0b/%h exp=1/fffffffffffffffc", bus.imem_req, bus.imem_addr); end
        step();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin failures++; $display("FAIL wrap_pc got=%0b/%h exp=1/fffffffffffffffc", bus.inst_valid, bus.inst_pc); end
        step();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) begin failures++; $display("FAIL wrap_next got=%0b/%h exp=1/0", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_misalign();
        lat = 0;
        do_reset();
        bus.inst_ready = 1'b0;
        step();
        step();
        bus.branch_redirect = 1'b1;
        bus.branch_target = 64'h102;
        step();
        bus.branch_redirect = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        for (int i = 0; i < 8; i++) begin
            bus.inst_ready = 1'(i % 2);
            checks++; if (bus.fetch_fault !== 1'b1 || bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0)
                begin failures++; $display("FAIL misalign_fault c%0d got=%0b/%0b/%0b exp=1/0/0", i, bus.fetch_fault, bus.imem_req, bus.inst_valid); end
            step();
        end
        do_reset();
        checks++; if (bus.fetch_fault !== 1'b0) begin failures++; $display("FAIL misalign_clear got=%0b exp=0", bus.fetch_fault); end
`else
        checks++; if (bus.fetch_fault !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h100)
            begin failures++; $display("FAIL misalign_mask got=%0b/%0b/%h exp=0/1/100", bus.fetch_fault, bus.imem_req, bus.imem_addr); end
`endif
    endtask

    task automatic test_random();
        logic [63:0] exp_pc, prev_addr, prev_pc;
        logic [31:0] prev_inst;
        bit          prev_wait, prev_hold;
        int          consumed;
        exp_pc = 64'h0;
        prev_wait = 1'b0;
        prev_hold = 1'b0;
        prev_addr = '0;
        prev_pc = '0;
        prev_inst = '0;
        consumed = 0;
        lat = 0;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (prev_wait) begin
                checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== prev_addr)
                    begin failures++; $display("FAIL rnd_addr_stable c%0d got=%0b/%h exp=1/%h", c, bus.imem_req, bus.imem_addr, prev_addr); end
            end
            if (prev_hold) begin
                checks++; if (bus.inst_valid !== 1'b1 || bus.instruction !== prev_inst || bus.inst_pc !== prev_pc)
                    begin failures++; $display("FAIL rnd_hold_stable c%0d got=%0b/%h/%h exp=1/%h/%h", c, bus.inst_valid, bus.instruction, bus.inst_pc, prev_inst, prev_pc); end
            end
            if (bus.imem_req) begin
                checks++; if (bus.imem_addr[1:0] !== 2'b00) begin failures++; $display("FAIL rnd_align c%0d got=%h exp=aligned", c, bus.imem_addr); end
            end
            bus.inst_ready = 1'($urandom_range(0, 1));
            bus.branch_redirect = ($urandom_range(0, 11) == 0);
            bus.branch_target = {$urandom, $urandom};
`ifdef IF_MISALIGN_TRAP_EN
            bus.branch_target[1:0] = 2'b00;
`endif
            if (bus.branch_redirect) begin
                exp_pc = bus.branch_target & ~64'h3;
            end else if (bus.inst_valid && bus.inst_ready) begin
                checks++; if (bus.inst_pc !== exp_pc || bus.instruction !== mem(exp_pc) || bus.opcode !== mem(exp_pc) >> 21)
                    begin failures++; $display("FAIL rnd_stream c%0d got=%h/%h/%h exp=%h/%h", c, bus.inst_pc, bus.instruction, bus.opcode, exp_pc, mem(exp_pc)); end
                exp_pc = exp_pc + 64'h4;
                consumed++;
            end
            prev_wait = bus.imem_req && !bus.imem_ack;
            prev_addr = bus.imem_addr;
            prev_hold = bus.inst_valid && !bus.inst_ready && !bus.branch_redirect;
            prev_inst = bus.instruction;
            prev_pc = bus.inst_pc;
            lat = $urandom_range(0, 3);
            step();
        end
        checks++; if (consumed < 200) begin failures++; $display("FAIL rnd_progress got=%0d exp>=200", consumed); end
        bus.branch_redirect = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_hold();
        test_redirect_drain();
        test_redirect_hold();
        test_wrap();
        test_misalign();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
